// File: rtl/data_memory_sized_if.sv
// rtl/data_memory_sized_if.sv - request/response bundle for the sized data memory
interface data_memory_sized_if #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int ERR_CNT_W   = 8
);
    logic                   MemWrite;
    logic                   MemRead;
    logic [1:0]             MemSize;
    logic                   MemSigned;
    logic [ADDR_LENGTH-1:0] addr;
    logic [DATA_LENGTH-1:0] writeData;
    logic [DATA_LENGTH-1:0] readData;
    logic                   readValid;
    logic                   memError;
    logic [ERR_CNT_W-1:0]   errCount;

    modport master (
        output MemWrite, MemRead, MemSize, MemSigned, addr, writeData,
        input  readData, readValid, memError, errCount
    );

    modport slave (
        input  MemWrite, MemRead, MemSize, MemSigned, addr, writeData,
        output readData, readValid, memError, errCount
    );
endinterface

// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte/half/word data memory with alignment/range checks and error counter
module data_memory_sized #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int DEPTH_LOG2  = 5,
    parameter int ERR_CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    data_memory_sized_if.slave bus
);
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef logic [DATA_LENGTH-1:0] word_t;

    word_t                 mem_q [DEPTH];
    word_t                 mem_d [DEPTH];
    word_t                 read_data_q, read_data_d;
    logic                  read_valid_q, read_valid_d;
    logic                  mem_error_q, mem_error_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            lane;
    logic                  in_range;
    logic                  aligned;
    logic                  legal;
    logic                  req;

    word_t                 cur_word;
    word_t                 lane_shifted;
    word_t                 load_ext;
    word_t                 lane_mask;
    word_t                 store_rep;
    word_t                 merged;

    // Storage holds contents XOR'd with the boot image, so an all-zero
    // power-up state reads back as word0=5, word1=10, rest 0.
    function automatic word_t boot_word(input logic [DEPTH_LOG2-1:0] idx);
        if (idx == DEPTH_LOG2'(0)) return word_t'(5);
        if (idx == DEPTH_LOG2'(1)) return word_t'(10);
        return '0;
    endfunction

    assign word_idx = bus.addr[DEPTH_LOG2+1:2];
    assign lane     = bus.addr[1:0];
    assign in_range = (bus.addr >> (DEPTH_LOG2 + 2)) == '0;
    assign req      = bus.MemRead | bus.MemWrite;
    assign legal    = aligned & in_range;

    always_comb begin
        aligned = 1'b0;
        case (bus.MemSize)
            SIZE_BYTE: aligned = 1'b1;
            SIZE_HALF: aligned = ~bus.addr[0];
            SIZE_WORD: aligned = (lane == 2'b00);
            default:   aligned = 1'b0;
        endcase
    end

    // Load extraction and store merge share the pre-write word, which is
    // what gives read-before-write on a combined request.
    always_comb begin
        cur_word     = mem_q[word_idx] ^ boot_word(word_idx);
        lane_shifted = cur_word >> {lane, 3'b000};
        load_ext     = lane_shifted;
        lane_mask    = '1;
        store_rep    = bus.writeData;
        case (bus.MemSize)
            SIZE_BYTE: begin
                load_ext  = {{(DATA_LENGTH-8){bus.MemSigned & lane_shifted[7]}}, lane_shifted[7:0]};
                lane_mask = word_t'(32'h0000_00FF) << {lane, 3'b000};
                store_rep = {4{bus.writeData[7:0]}};
            end
            SIZE_HALF: begin
                load_ext  = {{(DATA_LENGTH-16){bus.MemSigned & lane_shifted[15]}}, lane_shifted[15:0]};
                lane_mask = word_t'(32'h0000_FFFF) << {lane, 3'b000};
                store_rep = {2{bus.writeData[15:0]}};
            end
            default: begin
                load_ext  = lane_shifted;
                lane_mask = '1;
                store_rep = bus.writeData;
            end
        endcase
        merged = (cur_word & ~lane_mask) | (store_rep & lane_mask);
    end

    always_comb begin
        read_valid_d = req & legal & bus.MemRead;
        read_data_d  = read_valid_d ? load_ext : read_data_q;
        mem_error_d  = req & ~legal;
        err_count_d  = err_count_q;
        if (mem_error_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (bus.MemWrite && legal) begin
            mem_d[word_idx] = merged ^ boot_word(word_idx);
        end
    end

    // Memory is deliberately left out of the reset branch: it holds its
    // contents through reset and ignores requests while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            mem_error_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            mem_error_q  <= mem_error_d;
            err_count_q  <= err_count_d;
            mem_q        <= mem_d;
        end
    end

    assign bus.readData  = read_data_q;
    assign bus.readValid = read_valid_q;
    assign bus.memError  = mem_error_q;
    assign bus.errCount  = err_count_q;
endmodule

// File: tb/tb_data_memory_sized.sv
// tb/tb_data_memory_sized.sv - byte-level reference model plus directed vectors for data_memory_sized
module tb_data_memory_sized;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_sized_if #(.ADDR_LENGTH(32), .DATA_LENGTH(32), .ERR_CNT_W(8)) bus ();

    data_memory_sized #(
        .ADDR_LENGTH(32),
        .DATA_LENGTH(32),
        .DEPTH_LOG2 (5),
        .ERR_CNT_W  (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          total = 0;
    int          bad = 0;
    logic        cmp_en = 1'b0;
    logic [7:0]  mbytes [128];
    logic [31:0] exp_data = '0;
    logic        exp_valid = 1'b0;
    logic        exp_err = 1'b0;
    logic [7:0]  exp_cnt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total += 1;
        if (act !== req) begin
            bad += 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    // Memory modelled as a flat byte array; a request touches n consecutive bytes.
    task automatic model_step();
        int          n;
        logic [31:0] a;
        logic [31:0] v;
        logic        ok;
        a  = bus.addr;
        n  = (bus.MemSize == 2'b00) ? 1 : (bus.MemSize == 2'b01) ? 2 : 4;
        ok = (bus.MemSize != 2'b11) && ((a % n) == 0) && (a < 128);
        if (!(bus.MemRead || bus.MemWrite)) begin
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end else if (!ok) begin
            exp_valid = 1'b0;
            exp_err   = 1'b1;
            if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
        end else begin
            exp_err   = 1'b0;
            exp_valid = bus.MemRead;
            if (bus.MemRead) begin
                v = '0;
                for (int k = 0; k < n; k++) v = v | (32'(mbytes[a+k]) << (8*k));
                if (bus.MemSigned && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                exp_data = v;
            end
            if (bus.MemWrite) begin
                for (int k = 0; k < n; k++) mbytes[a+k] = bus.writeData[8*k +: 8];
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_data  = '0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            exp_cnt   = '0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_readData", bus.readData, exp_data);
            chk("cyc_readValid", 32'(bus.readValid), 32'(exp_valid));
            chk("cyc_memError", 32'(bus.memError), 32'(exp_err));
            chk("cyc_errCount", 32'(bus.errCount), 32'(exp_cnt));
        end
    end

    task automatic apply(input logic wr, input logic rd, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd);
        bus.MemWrite  = wr;
        bus.MemRead   = rd;
        bus.MemSize   = sz;
        bus.MemSigned = sg;
        bus.addr      = a;
        bus.writeData = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mbytes[i] = 8'h00;
        mbytes[0] = 8'd5;
        mbytes[4] = 8'd10;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemSize   = 2'b00;
        bus.MemSigned = 1'b0;
        bus.addr      = '0;
        bus.writeData = '0;
        #1;
        cmp_en = 1'b1;
        chk("rst_readData", bus.readData, 32'h0);
        chk("rst_readValid", 32'(bus.readValid), 32'h0);
        chk("rst_memError", 32'(bus.memError), 32'h0);
        chk("rst_errCount", 32'(bus.errCount), 32'h0);

        // Stores under reset must leave the boot image intact.
        apply(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF);
        apply(1'b1, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0000_00EE);
        rst_n = 1'b1;
        idle();

        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        chk("boot_w0", bus.readData, 32'd5);
        chk("boot_w0_valid", 32'(bus.readValid), 32'h1);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0);
        chk("boot_w1", bus.readData, 32'd10);
        chk("boot_w1_valid", 32'(bus.readValid), 32'h1);
        idle();
        chk("idle_valid", 32'(bus.readValid), 32'h0);
        chk("idle_hold", bus.readData, 32'd10);

        apply(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h1122_3344);
        apply(1'b1, 1'b0, 2'b00, 1'b0, 32'hA, 32'h0000_00AA);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0);
        chk("byte_merge", bus.readData, 32'h11AA_3344);

        apply(1'b1, 1'b0, 2'b01, 1'b0, 32'hC, 32'h0000_8001);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 32'hC, 32'h0);
        chk("half_signed", bus.readData, 32'hFFFF_8001);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 32'hC, 32'h0);
        chk("half_unsigned", bus.readData, 32'h0000_8001);
        apply(1'b0, 1'b1, 2'b00, 1'b1, 32'hD, 32'h0);
        chk("byte_signed", bus.readData, 32'hFFFF_FF80);
        apply(1'b0, 1'b1, 2'b00, 1'b0, 32'hD, 32'h0);
        chk("byte_unsigned", bus.readData, 32'h0000_0080);
        apply(1'b1, 1'b0, 2'b01, 1'b0, 32'hE, 32'h0000_BEEF);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'hC, 32'h0);
        chk("upper_half", bus.readData, 32'hBEEF_8001);

        apply(1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'hFFFF_FFFF);
        chk("misalign_err", 32'(bus.memError), 32'h1);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'h0);
        chk("range_err", 32'(bus.memError), 32'h1);
        chk("range_valid", 32'(bus.readValid), 32'h0);
        chk("err_cnt2", 32'(bus.errCount), 32'd2);
        chk("err_hold_data", bus.readData, 32'hBEEF_8001);
        idle();
        chk("err_pulse_end", 32'(bus.memError), 32'h0);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0);
        chk("w1_untouched", bus.readData, 32'd10);

        apply(1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 32'h1, 32'h0);
        chk("err_cnt4", 32'(bus.errCount), 32'd4);

        apply(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h1234_5678);
        chk("rbw_old", bus.readData, 32'd5);
        chk("rbw_valid", 32'(bus.readValid), 32'h1);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        chk("rbw_new", bus.readData, 32'h1234_5678);

        apply(1'b1, 1'b1, 2'b00, 1'b0, 32'h81, 32'h0);
        chk("rw_err_once", 32'(bus.errCount), 32'd5);

        apply(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hA5A5_0F0F);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0);
        chk("store_then_load", bus.readData, 32'h0000_A5A5);

        for (int i = 0; i < 300; i++) apply(1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0);
        chk("err_saturate", 32'(bus.errCount), 32'd255);

        bus.MemWrite = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_readData", bus.readData, 32'h0);
        chk("async_memError", 32'(bus.memError), 32'h0);
        chk("async_errCount", 32'(bus.errCount), 32'h0);
        @(posedge clk);
        #1;
        apply(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D);
        apply(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'hCAFE_F00D);
        rst_n = 1'b1;
        idle();
        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        chk("retain_w0", bus.readData, 32'h1234_5678);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0);
        chk("retain_w2", bus.readData, 32'h11AA_3344);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_memory_sized.md
DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

Interface
REQ-001 Parameter ADDR_LENGTH, default 32: byte-address width.
REQ-002 Parameter DATA_LENGTH, default 32: word width; SHALL be 32 (fixed, not a generalisation point); sub-word decode is defined for 4 bytes.
REQ-003 Parameter DEPTH_LOG2, default 5: memory holds 2^DEPTH_LOG2 words.
REQ-004 Parameter ERR_CNT_W, default 8: error counter width.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 MemWrite  input  1  store request this cycle.
REQ-008 MemRead  input  1  load request this cycle.
REQ-009 MemSize  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 MemSigned  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-011 addr  input  ADDR_LENGTH  byte address.
REQ-012 writeData  input  DATA_LENGTH  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-013 readData  output  DATA_LENGTH  registered load result.
REQ-014 readValid  output  1  readData updated this cycle.
REQ-015 memError  output  1  one-cycle pulse: previous request was rejected.
REQ-016 errCount  output  ERR_CNT_W  saturating count of rejected requests.

Function
REQ-017 Word index = addr[DEPTH_LOG2+1:2]; byte lane = addr[1:0].
REQ-018 Request is illegal if: MemSize=11; half with addr[0]=1; word with addr[1:0]!=00; or addr >= 4*2^DEPTH_LOG2 (out of range).
REQ-019 Legal store: on the posedge, write only the addressed lanes (byte: 1 lane; half: lanes 0-1 or 2-3; word: all 4); other lanes unchanged.
REQ-020 Legal load: on the posedge, read the addressed lanes; extend per MemSigned; register into readData; set readValid=1 for exactly the following cycle (latency 1).
REQ-021 Illegal request: no memory write; readData holds its value; readValid=0; memError=1 next cycle; errCount increments by 1, saturating at all-ones.
REQ-022 No request (MemRead=MemWrite=0): readValid=0, memError=0, readData holds.
REQ-023 MemRead and MemWrite both set, legal: the store is performed and the load returns the pre-store contents (read-before-write), readValid=1.
REQ-024 MemRead and MemWrite both set, illegal: counted once (errCount +1), memError=1.
REQ-025 Back-to-back loads sustain one result per cycle; a load immediately after a store to the same word returns the stored data.
REQ-026 Memory is not cleared by reset; initial contents: word 0 = 5, word 1 = 10, all others 0.

Reset
REQ-027 While rst_n=0: readData=0, readValid=0, memError=0, errCount=0, independent of clk.
REQ-028 Requests presented while rst_n=0 SHALL NOT modify memory; an assertion of reset mid-operation cancels any pending readValid/memError pulse.
REQ-029 First posedge with rst_n=1 accepts requests normally.

Verification
REQ-030 After reset, load word addr 0x0 then 0x4 on consecutive cycles -> readData 5 then 10, readValid high 2 cycles.
REQ-031 Word store 0x11223344 to 0x8; byte store 0xAA to 0xA; word load 0x8 -> 0x11AA3344.
REQ-032 Half store 0x8001 to 0xC; half load 0xC MemSigned=1 -> 0xFFFF8001; MemSigned=0 -> 0x00008001; byte load 0xD signed -> 0xFFFFFF80.
REQ-033 Word store to 0x6 (misaligned), then load to 0x80 (out of range, DEPTH_LOG2=5) -> memError pulses twice, errCount=2, word at 0x4 unchanged (10), readData unchanged.
REQ-034 Simultaneous read+write word 0x12345678 at 0x0 -> readData=5 next cycle; next load of 0x0 -> 0x12345678.
REQ-035 Drive 300 illegal requests with ERR_CNT_W=8 -> errCount saturates at 255; assert rst_n=0 mid-stream -> all outputs 0 asynchronously, memory contents retained.
